// File: rtl/imem_arbiter_pkg.sv
// Shared processor package: default memory geometry and the
// encoding of which requester currently owns the instruction memory port.
package imem_arbiter_pkg;

    localparam int IMEM_ADDR_WIDTH = 8;
    localparam int IMEM_DATA_WIDTH = 32;

    // Owner of the single memory port in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_e;

endpackage : imem_arbiter_pkg

// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: shares one single-port synchronous memory
// between the instruction fetch unit and a program loader. The loader has
// priority, but a saturating burst counter forces a fetch grant after
// MAX_BURST consecutive loader grants while fetch is waiting.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // fetch port (read only)
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    // loader port (read/write)
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [DATA_WIDTH-1:0] l_rdata,
    // memory command
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] BURST_ONE   = BURST_W'(1);

    owner_e                owner_s;
    logic [BURST_W-1:0]    burst_cnt_r;
    logic [BURST_W-1:0]    burst_cnt_nxt_s;
    logic                  burst_sat_s;
    logic                  f_rvalid_r;
    logic                  l_rvalid_r;
    logic [DATA_WIDTH-1:0] f_hold_r;
    logic [DATA_WIDTH-1:0] l_hold_r;

    assign burst_sat_s = (burst_cnt_r == BURST_LIMIT);

    // Decide who owns the memory port this cycle; nobody while in reset.
    always_comb begin
        owner_s = OWN_NONE;
        if (rst) begin
            owner_s = OWN_NONE;
        end else if (l_req && !(f_req && burst_sat_s)) begin
            owner_s = OWN_LOADER;
        end else if (f_req) begin
            owner_s = OWN_FETCH;
        end else begin
            owner_s = OWN_NONE;
        end
    end

    // Route the owner's request onto the memory command and raise its grant.
    always_comb begin
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (owner_s)
            OWN_FETCH: begin
                f_gnt    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = f_addr;
            end
            OWN_LOADER: begin
                l_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = l_we;
                mem_addr  = l_addr;
                mem_wdata = l_wdata;
            end
            default: begin
                f_gnt = 1'b0;
                l_gnt = 1'b0;
            end
        endcase
    end

    // Count loader grants that make a pending fetch wait; clear once fetch
    // is served or stops asking, and saturate at the limit.
    always_comb begin
        burst_cnt_nxt_s = burst_cnt_r;
        if (!f_req || (owner_s == OWN_FETCH)) begin
            burst_cnt_nxt_s = '0;
        end else if ((owner_s == OWN_LOADER) && !burst_sat_s) begin
            burst_cnt_nxt_s = burst_cnt_r + BURST_ONE;
        end else begin
            burst_cnt_nxt_s = burst_cnt_r;
        end
    end

    // Burst counter and read-valid pulses; reset cancels reads in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_r <= '0;
            f_rvalid_r  <= 1'b0;
            l_rvalid_r  <= 1'b0;
        end else begin
            burst_cnt_r <= burst_cnt_nxt_s;
            f_rvalid_r  <= f_gnt;
            l_rvalid_r  <= l_gnt & ~l_we;
        end
    end

    // Capture returned data so each port's rdata holds until its next rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_hold_r <= '0;
            l_hold_r <= '0;
        end else begin
            if (f_rvalid_r) begin
                f_hold_r <= mem_rdata;
            end
            if (l_rvalid_r) begin
                l_hold_r <= mem_rdata;
            end
        end
    end

    // The memory's data is live only in the rvalid cycle; otherwise show
    // the last value delivered on that port.
    assign f_rvalid = f_rvalid_r;
    assign l_rvalid = l_rvalid_r;
    assign f_rdata  = f_rvalid_r ? mem_rdata : f_hold_r;
    assign l_rdata  = l_rvalid_r ? mem_rdata : l_hold_r;

endmodule : imem_arbiter

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_imem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req, f_gnt, f_rvalid;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          l_req, l_we, l_gnt, l_rvalid;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // External single-port synchronous memory driven by the DUT command.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:255];
    int            fetch_wait;     // consecutive cycles fetch asked but lost
    bit            nxt_fv, nxt_lv; // read pulses due after the next edge
    logic [DW-1:0] nxt_fd, nxt_ld;
    logic [DW-1:0] exp_fd, exp_ld; // value each rdata must currently show
    bit            last_fg, last_lg, last_lwe;
    bit            obs_fg, obs_fv;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven; check combinational
    // outputs, advance the model, then check registered outputs.
    task automatic run_cycle();
        bit eg_f, eg_l;
        #1;
        if (rst) begin
            eg_f = 1'b0;
            eg_l = 1'b0;
            fetch_wait = 0;
            nxt_fv = 1'b0;
            nxt_lv = 1'b0;
            exp_fd = '0;
            exp_ld = '0;
            check_val("rst_f_rvalid", 64'(f_rvalid), 64'(0));
            check_val("rst_l_rvalid", 64'(l_rvalid), 64'(0));
            check_val("rst_f_rdata", 64'(f_rdata), 64'(0));
            check_val("rst_l_rdata", 64'(l_rdata), 64'(0));
        end else begin
            eg_l = l_req && !(f_req && fetch_wait >= MB);
            eg_f = f_req && !eg_l;
        end
        check_val("f_gnt", 64'(f_gnt), 64'(eg_f));
        check_val("l_gnt", 64'(l_gnt), 64'(eg_l));
        check_val("mem_en", 64'(mem_en), 64'(eg_f || eg_l));
        check_val("mem_we", 64'(mem_we), 64'(eg_l && l_we));
        if (eg_f) check_val("mem_addr_f", 64'(mem_addr), 64'(f_addr));
        if (eg_l) check_val("mem_addr_l", 64'(mem_addr), 64'(l_addr));
        if (eg_l && l_we) check_val("mem_wdata", 64'(mem_wdata), 64'(l_wdata));
        obs_fg = f_gnt;
        if (!rst) begin
            nxt_fv = eg_f;
            nxt_lv = eg_l && !l_we;
            if (eg_f) nxt_fd = ref_mem[f_addr];
            if (eg_l && !l_we) nxt_ld = ref_mem[l_addr];
            if (eg_l && l_we) ref_mem[l_addr] = l_wdata;
            fetch_wait = (f_req && !eg_f) ? fetch_wait + 1 : 0;
        end
        last_fg  = eg_f;
        last_lg  = eg_l;
        last_lwe = l_we;
        @(posedge clk);
        #1;
        if (nxt_fv) exp_fd = nxt_fd;
        if (nxt_lv) exp_ld = nxt_ld;
        check_val("f_rvalid", 64'(f_rvalid), 64'(nxt_fv));
        check_val("l_rvalid", 64'(l_rvalid), 64'(nxt_lv));
        check_val("f_rdata", 64'(f_rdata), 64'(exp_fd));
        check_val("l_rdata", 64'(l_rdata), 64'(exp_ld));
        obs_fv = f_rvalid;
    endtask

    initial begin
        int cnt;
        logic [DW-1:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[16]     = 32'h0050_0093;
        ref_mem[16] = 32'h0050_0093;
        fetch_wait = 0;
        nxt_fv = 1'b0; nxt_lv = 1'b0;
        nxt_fd = '0;   nxt_ld = '0;
        exp_fd = '0;   exp_ld = '0;
        f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

        // Reset with both requesters asking: grants must stay low.
        rst = 1'b1;
        f_req = 1'b1; l_req = 1'b1;
        run_cycle();
        run_cycle();
        rst = 1'b0;
        f_req = 1'b0; l_req = 1'b0;
        run_cycle();

        // Fetch alone from 0x10.
        f_req = 1'b1; f_addr = 8'h10;
        run_cycle();
        check_val("fetch_only_data", 64'(f_rdata), 64'(32'h0050_0093));
        f_req = 1'b0;
        run_cycle();

        // Loader write 0x20, then fetch it back.
        l_req = 1'b1; l_we = 1'b1; l_addr = 8'h20; l_wdata = 32'hDEAD_BEEF;
        run_cycle();
        l_req = 1'b0; l_we = 1'b0;
        f_req = 1'b1; f_addr = 8'h20;
        run_cycle();
        check_val("wr_then_fetch", 64'(f_rdata), 64'(32'hDEAD_BEEF));
        check_val("no_l_rvalid", 64'(l_rvalid), 64'(0));
        f_req = 1'b0;
        run_cycle();

        // Contention for 12 cycles: fetch wins on cycles 5 and 10.
        f_req = 1'b1; f_addr = 8'h01;
        l_req = 1'b1; l_we = 1'b0; l_addr = 8'h30;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            run_cycle();
            if (obs_fg) cnt++;
        end
        check_val("contention_fetch_wins", 64'(cnt), 64'(2));

        // Fetch withdraws after 2 loader grants, returns, waits 4 more.
        f_req = 1'b0; l_req = 1'b0;
        run_cycle();
        f_req = 1'b1; l_req = 1'b1;
        run_cycle();
        run_cycle();
        f_req = 1'b0;
        run_cycle();
        f_req = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            if (obs_fg) break;
            cnt++;
        end
        check_val("loader_grants_before_fetch", 64'(cnt), 64'(4));
        f_req = 1'b0; l_req = 1'b0;
        run_cycle();

        // Reset in the cycle after a fetch grant cancels its rvalid.
        f_req = 1'b1; f_addr = 8'h10; l_req = 1'b1; l_we = 1'b0;
        l_req = 1'b0;
        #1;
        f_req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("rst_cancel_rvalid", 64'(f_rvalid), 64'(0));
        check_val("rst_clear_rdata", 64'(f_rdata), 64'(0));
        run_cycle();
        rst = 1'b0;
        f_req = 1'b0;
        run_cycle();

        // Fetch 0x00..0x07 every cycle: eight back-to-back pulses.
        cnt = 0;
        for (int a = 0; a < 8; a++) begin
            f_req = 1'b1; f_addr = AW'(a);
            run_cycle();
            if (obs_fv) cnt++;
        end
        f_req = 1'b0;
        check_val("b2b_rvalid_count", 64'(cnt), 64'(8));
        run_cycle();

        // Randomized traffic with request hold, occasional fetch withdraw,
        // read-after-write to the same address and random resets.
        last_fg = 1'b0; last_lg = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!f_req || last_fg) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = AW'($urandom_range(0, 15));
            end else if ($urandom_range(0, 15) == 0) begin
                f_req = 1'b0;
            end
            if (!l_req || last_lg) begin
                if (last_lg && last_lwe && $urandom_range(0, 1) == 1) begin
                    l_req = 1'b1;
                    l_we  = 1'b0;
                end else begin
                    l_req   = ($urandom_range(0, 2) != 0);
                    l_we    = $urandom_range(0, 1) == 1;
                    l_addr  = AW'($urandom_range(0, 15));
                    l_wdata = $urandom;
                end
            end
            rst = ($urandom_range(0, 63) == 0);
            run_cycle();
        end
        rst = 1'b0;
        f_req = 1'b0; l_req = 1'b0;
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imem_arbiter
